// File: rtl/fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry instruction FIFO toward decode, an I-cache miss FSM,
// branch-redirect flush and a saturating miss counter.
//   state | meaning
//   RUN   | looking up PC each cycle; a hit with FIFO room enqueues and advances PC
//   MISS  | waiting for the cache to return a hit; PC held, decode keeps draining
module fetch_queue_stage #(
  parameter int               XLEN     = 32,
  parameter int               ILEN     = 32,
  parameter int               DEPTH    = 4,
  parameter int               PC_STEP  = 1,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  input  logic                       stall_d_i,
  output logic [XLEN-1:0]            ic_addr_o,
  input  logic                       ic_hit_i,
  input  logic [ILEN-1:0]            ic_data_i,
  output logic [ILEN-1:0]            instr_d_o,
  output logic [XLEN-1:0]            pc_d_o,
  output logic [XLEN-1:0]            pc_plus_d_o,
  output logic                       valid_d_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           miss_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP_C = XLEN'(PC_STEP);

  typedef enum logic {S_RUN, S_MISS} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [ILEN-1:0]   instr_mem_q   [DEPTH];
  logic [XLEN-1:0]   pc_mem_q      [DEPTH];
  logic [XLEN-1:0]   pc_plus_mem_q [DEPTH];

  logic              head_valid;
  logic              deq;
  logic              room;
  logic              enq;
  logic [XLEN-1:0]   pc_plus;

  assign head_valid = (count_q != '0);
  assign pc_plus    = pc_q + PC_STEP_C;
  assign deq        = head_valid & ~stall_d_i;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign room       = (count_q != DEPTH_C) | deq;
  assign enq        = (state_q == S_RUN) & ic_hit_i & room & ~redirect_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    miss_cnt_d = miss_cnt_q;
    if (redirect_i) begin
      state_d  = S_RUN;
      pc_d     = redirect_pc_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (!ic_hit_i) begin
            state_d = S_MISS;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
        S_MISS: begin
          if (ic_hit_i) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
      if (enq) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        pc_d     = pc_plus;
      end
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Storage is never reset; every read is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem_q[wr_ptr_q]   <= ic_data_i;
      pc_mem_q[wr_ptr_q]      <= pc_q;
      pc_plus_mem_q[wr_ptr_q] <= pc_plus;
    end
  end

  assign ic_addr_o   = pc_q;
  assign valid_d_o   = head_valid;
  assign instr_d_o   = head_valid ? instr_mem_q[rd_ptr_q]   : '0;
  assign pc_d_o      = head_valid ? pc_mem_q[rd_ptr_q]      : '0;
  assign pc_plus_d_o = head_valid ? pc_plus_mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_queue_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect_i, stall_d_i, ic_hit_i;
  logic [31:0] redirect_pc_i, ic_data_i, ic_addr_o, instr_d_o, pc_d_o, pc_plus_d_o;
  logic        valid_d_o;
  logic [2:0]  count_o;
  logic [15:0] miss_cnt_o;

  logic        rst2, r2_redirect, r2_stall, r2_hit;
  logic [31:0] r2_rpc, r2_data, r2_addr, r2_instr, r2_pc, r2_pc_plus;
  logic        r2_valid;
  logic [2:0]  r2_count;
  logic [3:0]  r2_miss;

  fetch_queue_stage dut (
    .clk(clk), .rst(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_d_i(stall_d_i), .ic_addr_o(ic_addr_o), .ic_hit_i(ic_hit_i), .ic_data_i(ic_data_i),
    .instr_d_o(instr_d_o), .pc_d_o(pc_d_o), .pc_plus_d_o(pc_plus_d_o), .valid_d_o(valid_d_o),
    .count_o(count_o), .miss_cnt_o(miss_cnt_o)
  );

  fetch_queue_stage #(.PC_STEP(4), .RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .redirect_i(r2_redirect), .redirect_pc_i(r2_rpc),
    .stall_d_i(r2_stall), .ic_addr_o(r2_addr), .ic_hit_i(r2_hit), .ic_data_i(r2_data),
    .instr_d_o(r2_instr), .pc_d_o(r2_pc), .pc_plus_d_o(r2_pc_plus), .valid_d_o(r2_valid),
    .count_o(r2_count), .miss_cnt_o(r2_miss)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_miss;
  logic [15:0] m_mcnt;

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'd0;
    m_miss = 1'b0;
    m_mcnt = 16'd0;
  endtask

  // One clock of the main DUT; the model advances by the same rules on the same edge.
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic st, input logic h);
    bit   deq, room;
    ent_t e;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    stall_d_i     = st;
    ic_hit_i      = h;
    ic_data_i     = ic_addr_o * 32'd3;
    @(posedge clk);
    deq  = (mq.size() > 0) && !st;
    room = (mq.size() < 4) || deq;
    if (rd) begin
      mq.delete();
      m_pc   = rpc;
      m_miss = 1'b0;
    end else begin
      if (deq) void'(mq.pop_front());
      if (m_miss) begin
        if (h) m_miss = 1'b0;
      end else if (!h) begin
        m_miss = 1'b1;
        if (m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
      end else if (room) begin
        e.pc    = m_pc;
        e.instr = m_pc * 32'd3;
        mq.push_back(e);
        m_pc = m_pc + 32'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic t2_cycle(input logic st, input logic h);
    r2_redirect = 1'b0;
    r2_rpc      = 32'd0;
    r2_stall    = st;
    r2_hit      = h;
    r2_data     = r2_addr ^ 32'hA5A5_0000;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'd0; stall_d_i = 1'b0; ic_hit_i = 1'b0; ic_data_i = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'd0; stall_d_i = 1'b0; ic_hit_i = 1'b0; ic_data_i = 32'd0;
    model_reset();
    #1;
    checks++;
    if ({valid_d_o, count_o, miss_cnt_o} !== 20'd0) begin
      failures++;
      $display("FAIL reset_status valid=%0b count=%0d miss=%0d required 0/0/0", valid_d_o, count_o, miss_cnt_o);
    end
    checks++;
    if ({instr_d_o, pc_d_o, pc_plus_d_o, ic_addr_o} !== 128'd0) begin
      failures++;
      $display("FAIL reset_data instr=%h pc=%h pc_plus=%h addr=%h required all 0", instr_d_o, pc_d_o, pc_plus_d_o, ic_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    checks++;
    if (valid_d_o !== 1'b0) begin
      failures++;
      $display("FAIL stream_pre_valid got=%0b required 0", valid_d_o);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      checks++;
      if ({valid_d_o, pc_d_o, instr_d_o, pc_plus_d_o} !== {1'b1, 32'(k), 32'(k * 3), 32'(k + 1)}) begin
        failures++;
        $display("FAIL stream k=%0d got v=%0b pc=%h i=%h pp=%h required v=1 pc=%h i=%h pp=%h",
                 k, valid_d_o, pc_d_o, instr_d_o, pc_plus_d_o, 32'(k), 32'(k * 3), 32'(k + 1));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      checks++;
      if ({count_o, ic_addr_o} !== {3'((i < 4) ? i : 4), 32'((i < 4) ? i : 4)}) begin
        failures++;
        $display("FAIL stall_fill i=%0d got count=%0d addr=%h required %0d", i, count_o, ic_addr_o, (i < 4) ? i : 4);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({valid_d_o, pc_d_o} !== {1'b1, 32'(i)}) begin
        failures++;
        $display("FAIL stall_drain i=%0d got v=%0b pc=%h required v=1 pc=%h", i, valid_d_o, pc_d_o, 32'(i));
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_miss();
    do_reset();
    repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({ic_addr_o, pc_d_o, count_o} !== {32'd6, 32'd2, 3'd4}) begin
      failures++;
      $display("FAIL miss_setup got addr=%h head=%h count=%0d required 6/2/4", ic_addr_o, pc_d_o, count_o);
    end
    for (int j = 1; j <= 5; j++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      checks++;
      if ({ic_addr_o, miss_cnt_o, valid_d_o, pc_d_o} !==
          {32'd6, 16'd1, 1'(j < 4), (j < 4) ? 32'(2 + j) : 32'd0}) begin
        failures++;
        $display("FAIL miss_hold j=%0d got addr=%h miss=%0d v=%0b head=%h", j, ic_addr_o, miss_cnt_o, valid_d_o, pc_d_o);
      end
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({valid_d_o, ic_addr_o} !== {1'b0, 32'd6}) begin
      failures++;
      $display("FAIL miss_return got v=%0b addr=%h required v=0 addr=6", valid_d_o, ic_addr_o);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({valid_d_o, pc_d_o, instr_d_o} !== {1'b1, 32'd6, 32'd18}) begin
      failures++;
      $display("FAIL miss_deliver got v=%0b pc=%h i=%h required v=1 pc=6 i=12", valid_d_o, pc_d_o, instr_d_o);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if ({count_o, miss_cnt_o} !== {3'd3, 16'd1}) begin
      failures++;
      $display("FAIL redirect_setup got count=%0d miss=%0d required 3/1", count_o, miss_cnt_o);
    end
    cycle(1'b1, 32'h40, 1'b1, 1'b0);
    checks++;
    if ({valid_d_o, count_o, ic_addr_o, miss_cnt_o, pc_d_o} !== {1'b0, 3'd0, 32'h40, 16'd1, 32'd0}) begin
      failures++;
      $display("FAIL redirect_flush got v=%0b count=%0d addr=%h miss=%0d head=%h", valid_d_o, count_o, ic_addr_o, miss_cnt_o, pc_d_o);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({valid_d_o, pc_d_o, pc_plus_d_o} !== {1'b1, 32'h40, 32'h41}) begin
      failures++;
      $display("FAIL redirect_first got v=%0b pc=%h pp=%h required pc=40 pp=41", valid_d_o, pc_d_o, pc_plus_d_o);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({valid_d_o, pc_d_o} !== {1'b1, 32'h41}) begin
      failures++;
      $display("FAIL redirect_second got v=%0b pc=%h required pc=41", valid_d_o, pc_d_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_d_o, count_o, miss_cnt_o, ic_addr_o, pc_d_o, instr_d_o} !== 116'd0) begin
      failures++;
      $display("FAIL async_reset got v=%0b count=%0d miss=%0d addr=%h pc=%h i=%h required all 0",
               valid_d_o, count_o, miss_cnt_o, ic_addr_o, pc_d_o, instr_d_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({valid_d_o, pc_d_o, ic_addr_o} !== {1'b1, 32'd0, 32'd1}) begin
      failures++;
      $display("FAIL async_restart got v=%0b pc=%h addr=%h required v=1 pc=0 addr=1", valid_d_o, pc_d_o, ic_addr_o);
    end
  endtask

  task automatic test_random();
    logic        rd, st, h, ev;
    logic [31:0] rpc, ep, ei, epp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      st  = ($urandom_range(0, 99) < 30);
      h   = ($urandom_range(0, 99) < 75);
      cycle(rd, rpc, st, h);
      ev  = (mq.size() != 0);
      ep  = ev ? mq[0].pc : 32'd0;
      ei  = ev ? mq[0].instr : 32'd0;
      epp = ev ? mq[0].pc + 32'd1 : 32'd0;
      checks++;
      if ({valid_d_o, pc_d_o, instr_d_o, pc_plus_d_o, count_o, miss_cnt_o, ic_addr_o} !==
          {ev, ep, ei, epp, 3'(mq.size()), m_mcnt, m_pc}) begin
        failures++;
        $display("FAIL random n=%0d got v=%0b pc=%h i=%h pp=%h cnt=%0d miss=%0d addr=%h required v=%0b pc=%h i=%h pp=%h cnt=%0d miss=%0d addr=%h",
                 n, valid_d_o, pc_d_o, instr_d_o, pc_plus_d_o, count_o, miss_cnt_o, ic_addr_o,
                 ev, ep, ei, epp, mq.size(), m_mcnt, m_pc);
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    @(negedge clk);
    rst2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t2_cycle(1'b0, 1'b1);
      checks++;
      if ({r2_valid, r2_pc, r2_pc_plus, r2_instr} !==
          {1'b1, exp_pc[k], exp_pc[k] + 32'd4, exp_pc[k] ^ 32'hA5A5_0000}) begin
        failures++;
        $display("FAIL pc_wrap k=%0d got v=%0b pc=%h pp=%h i=%h required pc=%h", k, r2_valid, r2_pc, r2_pc_plus, r2_instr, exp_pc[k]);
      end
    end
  endtask

  task automatic test_miss_sat();
    for (int k = 1; k <= 20; k++) begin
      t2_cycle(1'b0, 1'b0);
      checks++;
      if (r2_miss !== 4'((k < 15) ? k : 15)) begin
        failures++;
        $display("FAIL miss_sat k=%0d got=%0d required=%0d", k, r2_miss, (k < 15) ? k : 15);
      end
      t2_cycle(1'b0, 1'b1);
    end
  endtask

  initial begin
    rst2 = 1'b0; r2_redirect = 1'b0; r2_rpc = 32'd0; r2_stall = 1'b0; r2_hit = 1'b0; r2_data = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_miss();
    test_redirect();
    test_async_reset();
    test_random();
    test_pc_wrap();
    test_miss_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
